// File: rtl/serializer_pkg.sv
// serializer_pkg
//   Shared definitions for the parallel-to-serial converter:
//   - state_e     : the two controller states (IDLE, SHIFT)
//   - cnt_width() : bit width of the modulo-N bit counter
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // The counter must hold 0..n-1. One bit is the minimum width.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter
//   Modulo-N up counter that tracks which bit of the frame is on the wire.
//   Ports:
//     clk    - clock, rising edge
//     reset  - asynchronous active-high reset, forces count to 0
//     en     - advance the count by one (wraps N-1 -> 0)
//     clr    - synchronous clear, takes priority over en
//     tc_o   - terminal count, high while the count equals N-1
module mod_n_counter #(
  parameter int N = 8,
  parameter int W = serializer_pkg::cnt_width(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step with wrap at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == LAST);

endmodule

// File: rtl/parallel_serializer.sv
// parallel_serializer
//   Loads an N-bit word through a valid/ready handshake and shifts it out
//   one bit per enabled cycle, LSB-first or MSB-first.
//   Ports:
//     clk        - clock, rising edge
//     reset      - asynchronous active-high reset
//     data_i     - parallel word, sampled only on the load edge
//     load_valid - a word is offered on data_i
//     load_ready - the block is idle and will accept a word
//     en         - shift tick, one bit advances per edge with en=1
//     serial_o   - current serial bit (0 when idle)
//     frame_o    - high while serial_o carries a frame bit
//     done_o     - one-cycle pulse in the cycle after the last bit
module parallel_serializer
  import serializer_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_i,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         en,
  output logic         serial_o,
  output logic         frame_o,
  output logic         done_o
);

  localparam int CW = cnt_width(N);

  state_e       state_q, state_d;
  logic [N-1:0] shift_q, shift_d;
  logic         done_q,  done_d;

  logic load_fire;
  logic shift_fire;
  logic last_bit;

  // en is only meaningful while shifting, and a load takes the whole edge,
  // so an en arriving with the load never shifts.
  assign load_fire  = (state_q == IDLE)  && load_valid;
  assign shift_fire = (state_q == SHIFT) && en;

  mod_n_counter #(
    .N (N),
    .W (CW)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (shift_fire),
    .clr   (load_fire),
    .tc_o  (last_bit)
  );

  // State register: controller state, shift register and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  // Next state: load in IDLE, shift toward the output end in SHIFT, and
  // leave SHIFT on the enabled edge that moves past the last bit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shift_d = data_i;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (MSB_FIRST) begin
            shift_d = {shift_q[N-2:0], 1'b0};
          end else begin
            shift_d = {1'b0, shift_q[N-1:1]};
          end
          if (last_bit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so reset clears them
  // immediately and the first bit appears the cycle after the load edge.
  always_comb begin
    load_ready = (state_q == IDLE);
    frame_o    = (state_q == SHIFT);
    serial_o   = 1'b0;
    if (state_q == SHIFT) begin
      serial_o = MSB_FIRST ? shift_q[N-1] : shift_q[0];
    end
    done_o = done_q;
  end

endmodule

// File: tb/tb_parallel_serializer.sv
// tb_parallel_serializer
//   Drives an LSB-first and an MSB-first instance with identical stimulus and
//   compares both against a queue-based reference: a load pushes the word's
//   bits in wire order, each enabled shift pops one, and popping the last bit
//   schedules the done pulse.
module tb_parallel_serializer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic         en;
  logic [N-1:0] data_i;

  logic ready_l, serial_l, frame_l, done_l;
  logic ready_m, serial_m, frame_m, done_m;

  int checks   = 0;
  int failures = 0;

  bit         q_l[$];
  bit         q_m[$];
  logic       exp_done;
  logic [7:0] exp_v;
  wire  [7:0] obs = {ready_l, frame_l, serial_l, done_l,
                     ready_m, frame_m, serial_m, done_m};

  parallel_serializer #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .data_i     (data_i),
    .load_valid (load_valid),
    .load_ready (ready_l),
    .en         (en),
    .serial_o   (serial_l),
    .frame_o    (frame_l),
    .done_o     (done_l)
  );

  parallel_serializer #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .data_i     (data_i),
    .load_valid (load_valid),
    .load_ready (ready_m),
    .en         (en),
    .serial_o   (serial_m),
    .frame_o    (frame_m),
    .done_o     (done_m)
  );

  always #5 clk = ~clk;

  // Expected output vector from the current queue contents.
  function automatic void update_exp();
    logic busy;
    logic sl;
    logic sm;
    busy = (q_l.size() != 0);
    sl   = busy ? q_l[0] : 1'b0;
    sm   = busy ? q_m[0] : 1'b0;
    exp_v = {!busy, busy, sl, exp_done, !busy, busy, sm, exp_done};
  endfunction

  // Reference behaviour for one rising edge, using the inputs the DUT sees.
  task automatic model_step();
    exp_done = 1'b0;
    if (q_l.size() == 0) begin
      if (load_valid) begin
        for (int i = 0; i < N; i++) begin
          q_l.push_back(data_i[i]);
          q_m.push_back(data_i[N-1-i]);
        end
      end
    end else if (en) begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
      if (q_l.size() == 0) exp_done = 1'b1;
    end
    update_exp();
  endtask

  task automatic model_reset();
    q_l.delete();
    q_m.delete();
    exp_done = 1'b0;
    update_exp();
  endtask

  // Advance one edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    en         = 1'b0;
    data_i     = '0;
    model_reset();
    #2;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL reset_state: got %b want %b", obs, exp_v);
    end
    checks++;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // A5 with en held high: serial order, 8 frame cycles, done on cycle 9.
  task automatic test_a5_stream();
    logic [7:0] acc_l;
    logic [7:0] acc_m;
    int frame_cnt;
    int done_cyc;
    acc_l = '0; acc_m = '0; frame_cnt = 0; done_cyc = -1;
    load_valid = 1'b1; data_i = 8'hA5; en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      load_valid = 1'b0;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL a5_cycle%0d: got %b want %b", c, obs, exp_v);
      end
      checks++;
      if (frame_l) begin
        frame_cnt++;
        acc_l = {serial_l, acc_l[7:1]};
        acc_m = {acc_m[6:0], serial_m};
      end
      if (done_l && done_cyc < 0) done_cyc = c;
    end
    if (acc_l !== 8'hA5) begin failures++; $display("[TB] FAIL a5_lsb_word: got %h want a5", acc_l); end
    checks++;
    if (acc_m !== 8'hA5) begin failures++; $display("[TB] FAIL a5_msb_word: got %h want a5", acc_m); end
    checks++;
    if (frame_cnt != 8) begin failures++; $display("[TB] FAIL a5_frame_len: got %0d want 8", frame_cnt); end
    checks++;
    if (done_cyc != 9) begin failures++; $display("[TB] FAIL a5_done_cycle: got %0d want 9", done_cyc); end
    checks++;
  endtask

  // F0 with en toggling: each bit held two cycles, 16 frame cycles, one done.
  task automatic test_en_toggle();
    logic [7:0] acc_l;
    int frame_cnt;
    int done_cnt;
    acc_l = '0; frame_cnt = 0; done_cnt = 0;
    load_valid = 1'b1; data_i = 8'hF0; en = 1'b0;
    for (int k = -1; k <= 17; k++) begin
      if (k >= 0) en = k[0];
      cycle();
      load_valid = 1'b0;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL toggle_step%0d: got %b want %b", k, obs, exp_v);
      end
      checks++;
      if (frame_l) begin
        frame_cnt++;
        if (en === 1'b1 || k < 0) acc_l = acc_l;
      end
      if (frame_l && k >= 0 && k[0] == 1'b1) acc_l = {serial_l, acc_l[7:1]};
      if (done_l) done_cnt++;
    end
    if (frame_cnt != 16) begin failures++; $display("[TB] FAIL toggle_frame_len: got %0d want 16", frame_cnt); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("[TB] FAIL toggle_done_count: got %0d want 1", done_cnt); end
    checks++;
  endtask

  // 3C with a FF offered mid-frame: offer ignored, ready stays low.
  task automatic test_ignore_load();
    logic [7:0] acc_l;
    int ready_in_frame;
    acc_l = '0; ready_in_frame = 0;
    load_valid = 1'b1; data_i = 8'h3C; en = 1'b1;
    for (int k = -1; k <= 9; k++) begin
      if (k >= 0) begin
        load_valid = (k == 2 || k == 3);
        data_i     = 8'hFF;
      end
      cycle();
      if (k < 0) load_valid = 1'b0;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL ignore_step%0d: got %b want %b", k, obs, exp_v);
      end
      checks++;
      if (frame_l) begin
        acc_l = {serial_l, acc_l[7:1]};
        if (ready_l || ready_m) ready_in_frame++;
      end
    end
    load_valid = 1'b0;
    if (acc_l !== 8'h3C) begin failures++; $display("[TB] FAIL ignore_word: got %h want 3c", acc_l); end
    checks++;
    if (ready_in_frame != 0) begin failures++; $display("[TB] FAIL ignore_ready: got %0d want 0", ready_in_frame); end
    checks++;
  endtask

  // FF aborted by reset after 3 bits, then 01 reloaded.
  task automatic test_reset_mid_frame();
    logic [7:0] acc_l;
    int done_cnt;
    acc_l = '0; done_cnt = 0;
    load_valid = 1'b1; data_i = 8'hFF; en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cycle();
      load_valid = 1'b0;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL abort_cycle%0d: got %b want %b", c, obs, exp_v);
      end
      checks++;
    end
    reset = 1'b1;
    #1;
    model_reset();
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL abort_immediate: got %b want %b", obs, exp_v);
    end
    checks++;
    @(posedge clk);
    #1;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL abort_held: got %b want %b", obs, exp_v);
    end
    checks++;
    reset = 1'b0;
    load_valid = 1'b1; data_i = 8'h01;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      load_valid = 1'b0;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL reload_cycle%0d: got %b want %b", c, obs, exp_v);
      end
      checks++;
      if (frame_l) acc_l = {serial_l, acc_l[7:1]};
      if (done_l) done_cnt++;
    end
    if (acc_l !== 8'h01) begin failures++; $display("[TB] FAIL reload_word: got %h want 01", acc_l); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("[TB] FAIL reload_done_count: got %0d want 1", done_cnt); end
    checks++;
  endtask

  // 81 then 7E with load_valid held: one idle cycle between the frames.
  task automatic test_back_to_back();
    logic [16:0] fr;
    logic [7:0]  acc_l;
    logic [7:0]  acc_m;
    fr = '0; acc_l = '0; acc_m = '0;
    load_valid = 1'b1; data_i = 8'h81; en = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      cycle();
      data_i = 8'h7E;
      if (c == 17) load_valid = 1'b0;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL b2b_cycle%0d: got %b want %b", c, obs, exp_v);
      end
      checks++;
      if (c <= 17) fr[c-1] = frame_l;
      if (frame_l) begin
        acc_l = {serial_l, acc_l[7:1]};
        acc_m = {acc_m[6:0], serial_m};
      end
      if (c == 8) begin
        if (acc_l !== 8'h81 || acc_m !== 8'h81) begin
          failures++;
          $display("[TB] FAIL b2b_word1: got %h/%h want 81/81", acc_l, acc_m);
        end
        checks++;
      end
    end
    if (acc_l !== 8'h7E || acc_m !== 8'h7E) begin
      failures++;
      $display("[TB] FAIL b2b_word2: got %h/%h want 7e/7e", acc_l, acc_m);
    end
    checks++;
    if (fr !== 17'b11111111_0_11111111) begin
      failures++;
      $display("[TB] FAIL b2b_gap: got %b want 11111111011111111", fr);
    end
    checks++;
  endtask

  // Random offers, random shift ticks and random data against the model.
  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      load_valid = ($urandom_range(0, 1) == 1);
      en         = ($urandom_range(0, 3) != 0);
      data_i     = N'($urandom);
      cycle();
      if (obs !== exp_v) begin
        failures++;
        bad++;
        if (bad <= 10) $display("[TB] FAIL random_cycle%0d: got %b want %b", c, obs, exp_v);
      end
      checks++;
    end
    load_valid = 1'b0;
    en         = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a5_stream();
    test_en_toggle();
    test_ignore_load();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parallel_serializer.md
PARALLEL_SERIALIZER -- requirements
Module: parallel_serializer

Interface
REQ-001: Parameter N, default 8, is the parallel word width in bits; legal range 2..32.
REQ-002: Parameter MSB_FIRST, default 0, selects the serial bit order (0 = bit 0 first, 1 = bit N-1 first).
REQ-003: Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004: Port reset, input, 1 bit, is an asynchronous active-high reset.
REQ-005: Port data_i, input, N bits, carries the parallel word to serialize.
REQ-006: Port load_valid, input, 1 bit, means data_i holds a word offered for loading.
REQ-007: Port load_ready, output, 1 bit, means the block can accept a word this cycle.
REQ-008: Port en, input, 1 bit, is the shift-enable tick; one bit advances per cycle with en=1.
REQ-009: Port serial_o, output, 1 bit, carries the current serial bit.
REQ-010: Port frame_o, output, 1 bit, is high while serial_o carries a valid bit of the frame.
REQ-011: Port done_o, output, 1 bit, is a one-cycle pulse marking the end of a frame.

Function
REQ-012: The FSM SHALL have exactly the states IDLE and SHIFT.
REQ-013: In IDLE: load_ready=1, frame_o=0, serial_o=0.
REQ-014: A load SHALL occur on a clock edge where load_valid=1 and load_ready=1: capture data_i into the shift register, clear the bit counter, enter SHIFT.
REQ-015: In SHIFT: load_ready=0, frame_o=1, serial_o = shift_reg[0] (MSB_FIRST=0) or shift_reg[N-1] (MSB_FIRST=1).
REQ-016: The first bit SHALL appear on serial_o in the cycle immediately after the load edge (1-cycle latency).
REQ-017: In SHIFT, on each edge with en=1: shift the register one position toward the output end, fill with 0, and increment the counter.
REQ-018: In SHIFT with en=0, the register, counter and outputs SHALL hold.
REQ-019: On an edge in SHIFT with en=1 and counter=N-1, the FSM SHALL enter IDLE and assert done_o for exactly the following cycle.
REQ-020: The counter SHALL run 0..N-1 and wrap to 0 on frame completion, never exceeding N-1.
REQ-021: load_valid during SHIFT SHALL be ignored; data_i SHALL be sampled only at the load edge.
REQ-022: en in IDLE SHALL be ignored.
REQ-023: load_valid and en both high in IDLE SHALL load only, with no shift in that cycle.
REQ-024: After done_o, a new load MAY occur in the same cycle done_o is high, because load_ready=1 in IDLE. The back-to-back gap is therefore one cycle.

Reset
REQ-025: Asserting reset SHALL immediately force IDLE, shift register=0, counter=0, serial_o=0, frame_o=0, done_o=0, load_ready=1.
REQ-026: Reset mid-frame SHALL abort the frame without asserting done_o; operation resumes on the first edge after deassertion.

Structure
REQ-027: Package serializer_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the counter-width function or constant ($clog2(N)).
REQ-028: Sub-module mod_n_counter (modulo-N, enable, synchronous clear, asynchronous active-high reset, terminal-count output) SHALL implement the bit counter.

Verification
REQ-029: N=8, MSB_FIRST=0, load 8'hA5, en=1 constantly -> serial_o = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, frame_o high 8 cycles, done_o pulse on cycle 9.
REQ-030: N=8, MSB_FIRST=1, load 8'hA5 -> serial_o = 1,0,1,0,0,1,0,1 in MSB-first order (bit7..bit0), done_o after bit 0.
REQ-031: Load 8'hF0, en toggling 1,0,1,0... -> each bit is held for 2 cycles, frame_o is high 16 cycles, done_o fires once.
REQ-032: Load 8'h3C, pulse load_valid with data_i=8'hFF mid-frame -> output is still 8'h3C's bits, load_ready=0 throughout.
REQ-033: Load 8'hFF, assert reset after 3 bits -> all outputs reset immediately, no done_o; reload 8'h01 -> serial_o=1 then 0x7.
REQ-034: load_valid held high with data 8'h81 then 8'h7E -> the second frame starts in the cycle after done_o, with a 1-cycle gap of frame_o=0.
